// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction as a short sequence of register-file
// and CPSR accesses. Define WB_RETIRE_COUNT_EN to build the retired-instruction counter.
module writeback_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic        rd_we,
   input  logic [3:0]  rd,
   input  logic [31:0] rd_value,
   input  logic        rn_we,
   input  logic [3:0]  rn,
   input  logic [31:0] rn_value,
   input  logic        set_flags,
   input  logic [3:0]  nzcv,
   input  logic        restore_spsr,
   output logic        write_en,
   output logic [3:0]  write_reg,
   output logic [31:0] write_value,
   output logic        write_restore_from_SPSR,
   output logic        cpsr_read_en,
   input  logic [31:0] cpsr_read_value,
   output logic        cpsr_write_en,
   output logic [31:0] cpsr_write_value,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        retire,
   output logic [31:0] retire_count
);

   typedef enum logic [2:0] {
      IDLE, WR_RN, WR_RD, CPSR_RD, CPSR_WR, NOP
   } state_t;

   state_t state, state_next;

   logic        accept;
   logic        eff_restore;
   logic        need_rn;
   logic        need_cpsr;

   logic [3:0]  rn_q;
   logic [31:0] rn_value_q;
   logic [3:0]  rd_q;
   logic [31:0] rd_value_q;
   logic [3:0]  nzcv_q;
   logic        need_rd_q;
   logic        need_cpsr_q;
   logic        restore_q;

   // Only the condition-code nibble of the CPSR is replaced.
   logic        unused_cpsr_hi;
   assign unused_cpsr_hi = ^cpsr_read_value[31:28];

   assign wb_ready    = (state == IDLE);
   assign accept      = wb_valid && wb_ready;
   assign eff_restore = restore_spsr && rd_we && (rd == 4'd15);
   assign need_rn     = rn_we && !(rd_we && (rd == rn));
   assign need_cpsr   = set_flags && !eff_restore;

   // NOTE: state and payload are flops, so they use non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rn_q        <= '0;
         rn_value_q  <= '0;
         rd_q        <= '0;
         rd_value_q  <= '0;
         nzcv_q      <= '0;
         need_rd_q   <= 1'b0;
         need_cpsr_q <= 1'b0;
         restore_q   <= 1'b0;
      end else if (accept) begin
         rn_q        <= rn;
         rn_value_q  <= rn_value;
         rd_q        <= rd;
         rd_value_q  <= rd_value;
         nzcv_q      <= nzcv;
         need_rd_q   <= rd_we;
         need_cpsr_q <= need_cpsr;
         restore_q   <= eff_restore;
      end
   end

   // NOTE: every output gets a default first so no path leaves a latch behind.
   always_comb begin
      state_next              = state;
      write_en                = 1'b0;
      write_reg               = '0;
      write_value             = '0;
      write_restore_from_SPSR = 1'b0;
      cpsr_read_en            = 1'b0;
      cpsr_write_en           = 1'b0;
      cpsr_write_value        = '0;
      pc_redirect             = 1'b0;
      pc_target               = '0;
      retire                  = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               if (need_rn)        state_next = WR_RN;
               else if (rd_we)     state_next = WR_RD;
               else if (need_cpsr) state_next = CPSR_RD;
               else                state_next = NOP;
            end
         end
         WR_RN: begin
            write_en    = 1'b1;
            write_reg   = rn_q;
            write_value = rn_value_q;
            if (need_rd_q)        state_next = WR_RD;
            else if (need_cpsr_q) state_next = CPSR_RD;
            else                  state_next = IDLE;
            retire = !need_rd_q && !need_cpsr_q;
         end
         WR_RD: begin
            write_en                = 1'b1;
            write_reg               = rd_q;
            write_value             = rd_value_q;
            write_restore_from_SPSR = restore_q;
            state_next              = need_cpsr_q ? CPSR_RD : IDLE;
            retire                  = !need_cpsr_q;
         end
         CPSR_RD: begin
            cpsr_read_en = 1'b1;
            state_next   = CPSR_WR;
         end
         CPSR_WR: begin
            // Read data from the previous cycle is on cpsr_read_value now.
            cpsr_write_en    = 1'b1;
            cpsr_write_value = {nzcv_q, cpsr_read_value[27:0]};
            state_next       = IDLE;
            retire           = 1'b1;
         end
         NOP: begin
            state_next = IDLE;
            retire     = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      if (write_en && (write_reg == 4'd15)) begin
         pc_redirect = 1'b1;
         pc_target   = write_value;
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_count <= '0;
      end else if (retire) begin
         retire_count <= retire_count + 32'd1;
      end
   end
`else
   assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, reset
// corner cases and randomized transactions against an action-list model.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic        rd_we;
   logic [3:0]  rd;
   logic [31:0] rd_value;
   logic        rn_we;
   logic [3:0]  rn;
   logic [31:0] rn_value;
   logic        set_flags;
   logic [3:0]  nzcv;
   logic        restore_spsr;
   logic        write_en;
   logic [3:0]  write_reg;
   logic [31:0] write_value;
   logic        write_restore_from_SPSR;
   logic        cpsr_read_en;
   logic [31:0] cpsr_read_value;
   logic        cpsr_write_en;
   logic [31:0] cpsr_write_value;
   logic        pc_redirect;
   logic [31:0] pc_target;
   logic        retire;
   logic [31:0] retire_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rc = '0;

   writeback_stage dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .rd_we(rd_we), .rd(rd), .rd_value(rd_value),
      .rn_we(rn_we), .rn(rn), .rn_value(rn_value),
      .set_flags(set_flags), .nzcv(nzcv), .restore_spsr(restore_spsr),
      .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
      .write_restore_from_SPSR(write_restore_from_SPSR),
      .cpsr_read_en(cpsr_read_en), .cpsr_read_value(cpsr_read_value),
      .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
      .pc_redirect(pc_redirect), .pc_target(pc_target),
      .retire(retire), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wb_ready;
      logic        write_en;
      logic [3:0]  write_reg;
      logic [31:0] write_value;
      logic        wsr;
      logic        cpsr_read_en;
      logic        cpsr_write_en;
      logic [31:0] cpsr_write_value;
      logic        pc_redirect;
      logic [31:0] pc_target;
      logic        retire;
   } obs_t;

   typedef struct {
      logic        rd_we;
      logic [3:0]  rd;
      logic [31:0] rd_value;
      logic        rn_we;
      logic [3:0]  rn;
      logic [31:0] rn_value;
      logic        set_flags;
      logic [3:0]  nzcv;
      logic        restore;
      logic [31:0] cpsr_in;
   } txn_t;

   typedef struct {
      string       name;
      txn_t        t;
      int          exp_cycles;
      int          exp_writes;
      logic [31:0] exp_cwv;
      logic [31:0] exp_tgt;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.wb_ready         = wb_ready;
      o.write_en         = write_en;
      o.write_reg        = write_reg;
      o.write_value      = write_value;
      o.wsr              = write_restore_from_SPSR;
      o.cpsr_read_en     = cpsr_read_en;
      o.cpsr_write_en    = cpsr_write_en;
      o.cpsr_write_value = cpsr_write_value;
      o.pc_redirect      = pc_redirect;
      o.pc_target        = pc_target;
      o.retire           = retire;
      return o;
   endfunction

   function automatic obs_t idle_obs();
      obs_t o = '0;
      o.wb_ready = 1'b1;
      return o;
   endfunction

   function automatic obs_t wr_obs(input logic [3:0] r, input logic [31:0] v, input logic s);
      obs_t o = '0;
      o.write_en    = 1'b1;
      o.write_reg   = r;
      o.write_value = v;
      o.wsr         = s;
      if (r == 4'd15) begin
         o.pc_redirect = 1'b1;
         o.pc_target   = v;
      end
      return o;
   endfunction

   task automatic randomize_payload();
      rd_we = 1'($urandom); rd = 4'($urandom); rd_value = $urandom;
      rn_we = 1'($urandom); rn = 4'($urandom); rn_value = $urandom;
      set_flags = 1'($urandom); nzcv = 4'($urandom); restore_spsr = 1'($urandom);
   endtask

   task automatic bump_rc();
`ifdef WB_RETIRE_COUNT_EN
      exp_rc = exp_rc + 32'd1;
`endif
   endtask

   // Model: the instruction is a list of register-file / CPSR actions,
   // one per cycle, with retire on the final one.
   task automatic run_txn(input txn_t t, input bit garbage, output int cycles,
                          output int writes, output logic [31:0] cwv, output logic [31:0] tgt);
      obs_t exp_q[$];
      obs_t o, e;
      bit eff_restore;
      eff_restore = t.restore && t.rd_we && (t.rd == 4'd15);
      if (t.rn_we && !(t.rd_we && t.rd == t.rn)) exp_q.push_back(wr_obs(t.rn, t.rn_value, 1'b0));
      if (t.rd_we) exp_q.push_back(wr_obs(t.rd, t.rd_value, eff_restore));
      if (t.set_flags && !eff_restore) begin
         e = '0; e.cpsr_read_en = 1'b1; exp_q.push_back(e);
         e = '0; e.cpsr_write_en = 1'b1; e.cpsr_write_value = {t.nzcv, t.cpsr_in[27:0]};
         exp_q.push_back(e);
      end
      if (exp_q.size() == 0) exp_q.push_back('0);
      exp_q[exp_q.size()-1].retire = 1'b1;

      cycles = 0; writes = 0; cwv = '0; tgt = '0;
      @(negedge clk);
      check("ready_before_accept", 128'(wb_ready), 128'(1));
      rd_we = t.rd_we; rd = t.rd; rd_value = t.rd_value;
      rn_we = t.rn_we; rn = t.rn; rn_value = t.rn_value;
      set_flags = t.set_flags; nzcv = t.nzcv; restore_spsr = t.restore;
      cpsr_read_value = t.cpsr_in;
      wb_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (garbage) randomize_payload(); else wb_valid = 1'b0;
         o = sample();
         check($sformatf("cycle%0d", i), 128'(o), 128'(exp_q[i]));
         if (!o.wb_ready) cycles++;
         if (o.write_en) writes++;
         if (o.cpsr_write_en) cwv = o.cpsr_write_value;
         if (o.pc_redirect) tgt = o.pc_target;
         @(posedge clk); #1;
      end
      check("idle_after", 128'(sample()), 128'(idle_obs()));
      wb_valid = 1'b0;
      bump_rc();
      check("retire_count", 128'(retire_count), 128'(exp_rc));
   endtask

   vec_t vecs[8];

   initial begin
      int cyc, wr;
      logic [31:0] cwv, tgt;
      txn_t t;

      vecs[0] = '{"ldr_post", '{1, 4, 32'hDEADBEEF, 1, 13, 32'h1004, 0, 0, 0, 0}, 2, 2, 0, 0};
      vecs[1] = '{"rd_eq_rn", '{1, 5, 32'h11, 1, 5, 32'h22, 0, 0, 0, 0}, 1, 1, 0, 0};
      vecs[2] = '{"adds", '{1, 2, 32'h0, 0, 0, 0, 1, 4'b0100, 0, 32'h600000D3}, 3, 1, 32'h400000D3, 0};
      vecs[3] = '{"movs_pc", '{1, 15, 32'h3004, 0, 0, 0, 1, 4'hF, 1, 32'h12345678}, 1, 1, 0, 32'h3004};
      vecs[4] = '{"cmp_noflags", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0, 0};
      vecs[5] = '{"flags_only", '{0, 0, 0, 0, 0, 0, 1, 4'hA, 1, 32'hFFFFFFFF}, 2, 0, 32'hAFFFFFFF, 0};
      vecs[6] = '{"restore_ignored", '{1, 3, 32'h33, 0, 0, 0, 1, 4'h1, 1, 32'h0000001F}, 3, 1, 32'h1000001F, 0};
      vecs[7] = '{"rn_pc", '{1, 1, 32'h77, 1, 15, 32'h100, 0, 0, 0, 0}, 2, 2, 0, 32'h100};

      rst = 1'b1; wb_valid = 1'b0; cpsr_read_value = '0;
      randomize_payload();
      #1;
      check("reset_outputs", 128'(sample()), 128'(idle_obs()));
      check("reset_count", 128'(retire_count), 128'(0));
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) begin
         run_txn(vecs[i].t, 1'b0, cyc, wr, cwv, tgt);
         check({vecs[i].name, "_cycles"}, 128'(cyc), 128'(vecs[i].exp_cycles));
         check({vecs[i].name, "_writes"}, 128'(wr), 128'(vecs[i].exp_writes));
         check({vecs[i].name, "_cpsr"}, 128'(cwv), 128'(vecs[i].exp_cwv));
         check({vecs[i].name, "_target"}, 128'(tgt), 128'(vecs[i].exp_tgt));
      end

      // Reset during WR_RN of a two-write op: the R4 write never happens.
      @(negedge clk);
      rd_we = 1; rd = 4; rd_value = 32'hDEADBEEF; rn_we = 1; rn = 13; rn_value = 32'h1004;
      set_flags = 1; nzcv = 4'hF; restore_spsr = 0; wb_valid = 1'b1;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      check("pre_reset_wr_rn", 128'({write_en, write_reg}), 128'({1'b1, 4'd13}));
      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs", 128'(sample()), 128'(idle_obs()));
      exp_rc = '0;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_reset_quiet", 128'(sample()), 128'(idle_obs()));
      end
      check("post_reset_count", 128'(retire_count), 128'(0));

      for (int i = 0; i < 3; i++) run_txn(vecs[4].t, 1'b0, cyc, wr, cwv, tgt);
`ifdef WB_RETIRE_COUNT_EN
      check("three_retires", 128'(retire_count), 128'(3));
`else
      check("three_retires", 128'(retire_count), 128'(0));
`endif

      for (int n = 0; n < 300; n++) begin
         t.rd_we = 1'($urandom); t.rd = 4'($urandom);
         if ($urandom_range(0, 3) == 0) t.rd = 4'd15;
         t.rd_value = $urandom;
         t.rn_we = 1'($urandom); t.rn = 4'($urandom);
         if ($urandom_range(0, 2) == 0) t.rn = t.rd;
         t.rn_value = $urandom;
         t.set_flags = 1'($urandom); t.nzcv = 4'($urandom);
         t.restore = 1'($urandom); t.cpsr_in = $urandom;
         run_txn(t, 1'($urandom), cyc, wr, cwv, tgt);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            check("gap_idle", 128'(sample()), 128'(idle_obs()));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
